// File: rtl/digit_scan_pkg.sv
// Shared constants for the multiplexed 7-segment display stage:
// segment bit positions, the hex-to-segment table and the buffer entry type.
package digit_scan_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned SEG_W    = 8;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned DP_BIT = 7;

    localparam logic [SEG_W-1:0] SEG_ALL_OFF_AH = 8'h00;

    // Active-high {dp,g,f,e,d,c,b,a}; entry 0 is the least significant byte.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    typedef struct packed {
        logic [NIBBLE_W-1:0] value;
        logic                valid;
    } digit_t;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] v);
        return HEX_SEG_TABLE[v];
    endfunction

endpackage

// File: rtl/digit_scan_if.sv
// Number input strobes and scanned display outputs of the display stage.
interface digit_scan_if #(
    parameter int unsigned DIGITS = 4
);
    logic [3:0]        Number_Data;
    logic              Number_Valid;
    logic              Clear_Sig;
    logic [7:0]        Row_Scan_Sig;
    logic [DIGITS-1:0] Column_Scan_Sig;

    modport master (
        output Number_Data, Number_Valid, Clear_Sig,
        input  Row_Scan_Sig, Column_Scan_Sig
    );

    modport slave (
        input  Number_Data, Number_Valid, Clear_Sig,
        output Row_Scan_Sig, Column_Scan_Sig
    );
endinterface

// File: rtl/seg_decode_module.sv
// Combinational hex-to-7-segment decode, active-high; blank forces all segments off.
module seg_decode_module
    import digit_scan_pkg::*;
(
    input  logic [NIBBLE_W-1:0] value,
    input  logic                blank,
    output logic [SEG_W-1:0]    seg_c
);

    always_comb begin
        seg_c = SEG_ALL_OFF_AH;
        if (!blank) begin
            seg_c = hex_to_seg(value);
        end
        seg_c[DP_BIT] = 1'b0;
    end

endmodule

// File: rtl/digit_scan_module.sv
// Display stage: keeps the last DIGITS received nibbles and scans them onto a
// multiplexed 7-segment display, one digit slot per SCAN_DIV clocks.
module digit_scan_module
    import digit_scan_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          COL_ACT_LOW = 1'b1
) (
    input  logic         CLK,
    input  logic         RSTn,
    digit_scan_if.slave  bus
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SEG_W-1:0]  SEG_OFF = SEG_ACT_LOW ? 8'hFF : SEG_ALL_OFF_AH;
    localparam logic [DIGITS-1:0] COL_OFF = COL_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    digit_t [DIGITS-1:0] digits;
    logic [CNT_W-1:0]    scan_cnt;
    logic [IDX_W-1:0]    idx;
    logic                started;
    logic                slot_start;
    logic                col_on;
    logic [SEG_W-1:0]    row_q;
    logic [DIGITS-1:0]   col_q;

    logic                tc_c;
    digit_t              cur_c;
    logic [SEG_W-1:0]    seg_c;
    logic [SEG_W-1:0]    seg_pol_c;
    logic [DIGITS-1:0]   col_sel_c;
    logic [DIGITS-1:0]   col_pol_c;

    // Nibble shift buffer; clear takes priority over a simultaneous number.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            digits <= '0;
        end else if (bus.Clear_Sig) begin
            digits <= '0;
        end else if (bus.Number_Valid) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                digits[i] <= digits[i-1];
            end
            digits[0].value <= bus.Number_Data;
            digits[0].valid <= 1'b1;
        end
    end

    assign tc_c = (scan_cnt == CNT_W'(SCAN_DIV - 1));

    // Time base; the first terminal count only arms the scan so digit 0 shows first.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            scan_cnt   <= '0;
            idx        <= '0;
            started    <= 1'b0;
            slot_start <= 1'b0;
        end else begin
            slot_start <= tc_c;
            if (tc_c) begin
                scan_cnt <= '0;
                started  <= 1'b1;
                if (started) begin
                    idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
                end
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
        end
    end

    assign cur_c = digits[idx];

    seg_decode_module u_seg_decode (
        .value (cur_c.value),
        .blank (!cur_c.valid),
        .seg_c (seg_c)
    );

    assign seg_pol_c = SEG_ACT_LOW ? ~seg_c : seg_c;
    assign col_sel_c = DIGITS'(1) << idx;
    assign col_pol_c = COL_ACT_LOW ? ~col_sel_c : col_sel_c;

    // Column and segments load together at a slot start; segments track the buffer in between.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            row_q  <= SEG_OFF;
            col_q  <= COL_OFF;
            col_on <= 1'b0;
        end else if (slot_start) begin
            row_q  <= seg_pol_c;
            col_q  <= col_pol_c;
            col_on <= 1'b1;
        end else if (col_on) begin
            row_q  <= seg_pol_c;
        end
    end

    assign bus.Row_Scan_Sig    = row_q;
    assign bus.Column_Scan_Sig = col_q;

endmodule
